// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
//   ictl_state_e   : controller FSM state encoding (2 bits, visible in STATUS)
//   ICTL_ADDR_*    : register word offsets on the bridge
//   ICTL_*_LSB     : field positions inside the STATUS word
package irq_ctrl_pkg;

  localparam int unsigned ICTL_DATA_W    = 32;
  localparam int unsigned ICTL_ADDR_W    = 2;
  localparam int unsigned ICTL_STATE_W   = 2;
  localparam int unsigned ICTL_STATE_LSB = 8;
  localparam int unsigned ICTL_ID_LSB    = 4;

  typedef enum logic [ICTL_STATE_W-1:0] {
    ICTL_IDLE    = 2'b00,
    ICTL_REQ     = 2'b01,
    ICTL_SERVICE = 2'b10
  } ictl_state_e;

  localparam logic [ICTL_ADDR_W-1:0] ICTL_ADDR_MASK   = 2'd0;
  localparam logic [ICTL_ADDR_W-1:0] ICTL_ADDR_PEND   = 2'd1;
  localparam logic [ICTL_ADDR_W-1:0] ICTL_ADDR_EDGE   = 2'd2;
  localparam logic [ICTL_ADDR_W-1:0] ICTL_ADDR_STATUS = 2'd3;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder.
//   req   in  N  request vector (bit 0 has highest priority)
//   valid out 1  any request set
//   idx   out W  index of the lowest set bit (0 when none)
module prio_enc #(
  parameter int unsigned N = 6,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // First set bit from index 0 upwards wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller between interrupt sources and the CPU pipeline.
// Synchronises HWInt, latches pending bits (level or edge per source),
// masks, selects the highest-priority source and runs the
// request / acknowledge / return handshake.
//   Clk, Reset     clock, synchronous active-high reset
//   Addr, Wd, We   register write port (0 MASK, 1 PEND w1c, 2 EDGE, 3 STATUS ro)
//   Rd             combinational read data selected by Addr
//   HWInt          raw interrupt lines, bit 0 = timer
//   IntReq, IntId  registered request and source index to the pipeline
//   IntAck, Eret   single-cycle exception-entry / handler-return pulses
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 6,
  parameter int unsigned ID_W  = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [ICTL_ADDR_W-1:0] Addr,
  input  logic [ICTL_DATA_W-1:0] Wd,
  input  logic                   We,
  output logic [ICTL_DATA_W-1:0] Rd,
  input  logic [N_SRC-1:0]       HWInt,
  output logic                   IntReq,
  output logic [ID_W-1:0]        IntId,
  input  logic                   IntAck,
  input  logic                   Eret
);

  ictl_state_e state_q, state_d;

  logic [N_SRC-1:0] hw_s, hw_d;
  logic [N_SRC-1:0] mask_q, edge_q, pend_q, pend_d;
  logic [N_SRC-1:0] active, rise, w1c, id_hit;
  logic             any_active, id_active, ack_clr;
  logic             int_req_d;
  logic [ID_W-1:0]  int_id_d, winner;

  // Upper write-data bits have no register behind them.
  logic unused_wd;
  assign unused_wd = ^Wd[ICTL_DATA_W-1:N_SRC];

  assign active = pend_q & mask_q;
  assign rise   = hw_s & ~hw_d;
  assign w1c    = (We && Addr == ICTL_ADDR_PEND) ? Wd[N_SRC-1:0] : '0;

  // One-hot decode of IntId; avoids indexing past N_SRC.
  always_comb begin
    id_hit = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      id_hit[i] = (IntId == ID_W'(i));
    end
  end

  assign id_active = |(active & id_hit);

  prio_enc #(
    .N (N_SRC),
    .W (ID_W)
  ) u_prio_enc (
    .req   (active),
    .valid (any_active),
    .idx   (winner)
  );

  // Pending bits: level sources follow the synchronised line; edge sources
  // latch a rising edge and clear on w1c or acknowledge, set beats clear.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (edge_q[i]) begin
        pend_d[i] = rise[i] | (pend_q[i] & ~(w1c[i] | (ack_clr & id_hit[i])));
      end else begin
        pend_d[i] = hw_s[i];
      end
    end
  end

  // Synchroniser, edge detector and software-visible registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hw_s   <= '0;
      hw_d   <= '0;
      mask_q <= '0;
      edge_q <= '0;
      pend_q <= '0;
    end else begin
      hw_s   <= HWInt;
      hw_d   <= hw_s;
      pend_q <= pend_d;
      if (We && Addr == ICTL_ADDR_MASK) mask_q <= Wd[N_SRC-1:0];
      if (We && Addr == ICTL_ADDR_EDGE) edge_q <= Wd[N_SRC-1:0];
    end
  end

  // FSM state register together with the registered pipeline outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ICTL_IDLE;
      IntReq  <= 1'b0;
      IntId   <= '0;
    end else begin
      state_q <= state_d;
      IntReq  <= int_req_d;
      IntId   <= int_id_d;
    end
  end

  // Next-state logic. IntAck takes priority over a vanishing request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ICTL_IDLE:    if (any_active) state_d = ICTL_REQ;
      ICTL_REQ: begin
        if (IntAck)          state_d = ICTL_SERVICE;
        else if (!id_active) state_d = ICTL_IDLE;
      end
      ICTL_SERVICE: if (Eret) state_d = ICTL_IDLE;
      default:      state_d = ICTL_IDLE;
    endcase
  end

  // Output logic; IntId only changes on IDLE -> REQ (no preemption).
  always_comb begin
    int_req_d = IntReq;
    int_id_d  = IntId;
    ack_clr   = 1'b0;
    case (state_q)
      ICTL_IDLE: begin
        if (any_active) begin
          int_req_d = 1'b1;
          int_id_d  = winner;
        end
      end
      ICTL_REQ: begin
        if (IntAck) begin
          int_req_d = 1'b0;
          ack_clr   = 1'b1;
        end else if (!id_active) begin
          int_req_d = 1'b0;
        end
      end
      default: int_req_d = 1'b0;
    endcase
  end

  // Read mux.
  always_comb begin
    Rd = '0;
    case (Addr)
      ICTL_ADDR_MASK: Rd[N_SRC-1:0] = mask_q;
      ICTL_ADDR_PEND: Rd[N_SRC-1:0] = pend_q;
      ICTL_ADDR_EDGE: Rd[N_SRC-1:0] = edge_q;
      default: begin
        Rd[ICTL_STATE_LSB +: ICTL_STATE_W] = state_q;
        Rd[ICTL_ID_LSB +: ID_W]            = IntId;
        Rd[0]                              = IntReq;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  Addr = '0;
  logic [31:0] Wd = '0;
  logic        We = 1'b0;
  logic [31:0] Rd;
  logic [5:0]  HWInt = '0;
  logic        IntReq;
  logic [2:0]  IntId;
  logic        IntAck = 1'b0;
  logic        Eret = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.N_SRC(6), .ID_W(3)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Addr   (Addr),
    .Wd     (Wd),
    .We     (We),
    .Rd     (Rd),
    .HWInt  (HWInt),
    .IntReq (IntReq),
    .IntId  (IntId),
    .IntAck (IntAck),
    .Eret   (Eret)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n posedges, land 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; Wd = d; We = 1'b1;
    tick(1);
    We = 1'b0; Wd = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    check(tag, Rd, exp);
  endtask

  task automatic ack;
    IntAck = 1'b1; tick(1); IntAck = 1'b0;
  endtask

  task automatic eret;
    Eret = 1'b1; tick(1); Eret = 1'b0;
  endtask

  task automatic do_reset;
    HWInt = '0; Reset = 1'b1; tick(2); Reset = 1'b0;
  endtask

  initial begin
    // 1: reset values, timer latency, ack, eret re-request
    do_reset();
    check("rst_req", 32'(IntReq), 32'd0);
    check("rst_id", 32'(IntId), 32'd0);
    rd_chk("rst_mask", 2'd0, 32'h0);
    rd_chk("rst_pend", 2'd1, 32'h0);
    rd_chk("rst_edge", 2'd2, 32'h0);
    rd_chk("rst_status", 2'd3, 32'h0);
    wr(2'd0, 32'h1);
    rd_chk("mask_rb", 2'd0, 32'h1);
    HWInt = 6'h01;
    tick(2);
    check("t1_req_early", 32'(IntReq), 32'd0);
    tick(1);
    check("t1_req", 32'(IntReq), 32'd1);
    check("t1_id", 32'(IntId), 32'd0);
    ack();
    check("t1_ack_req", 32'(IntReq), 32'd0);
    rd_chk("t1_svc_status", 2'd3, 32'h200);
    tick(3);
    check("t1_svc_hold", 32'(IntReq), 32'd0);
    eret();
    rd_chk("t1_eret_idle", 2'd3, 32'h000);
    tick(1);
    check("t1_rereq", 32'(IntReq), 32'd1);
    rd_chk("t1_rereq_status", 2'd3, 32'h101);

    // 2: masked sources, level w1c ignored, stray ack/eret, unmask
    do_reset();
    HWInt = 6'h3F;
    IntAck = 1'b1; Eret = 1'b1;
    tick(1);
    IntAck = 1'b0; Eret = 1'b0;
    tick(19);
    check("t2_masked_req", 32'(IntReq), 32'd0);
    rd_chk("t2_pend", 2'd1, 32'h3F);
    rd_chk("t2_stray_status", 2'd3, 32'h0);
    wr(2'd1, 32'h3F);
    tick(1);
    rd_chk("t2_level_w1c", 2'd1, 32'h3F);
    wr(2'd0, 32'h14);
    tick(1);
    check("t2_req", 32'(IntReq), 32'd1);
    check("t2_id", 32'(IntId), 32'd2);

    // 3: edge source pulse, ack clears, w1c vs new edge
    do_reset();
    wr(2'd2, 32'h08);
    wr(2'd0, 32'h3F);
    HWInt = 6'h08;
    tick(1);
    HWInt = 6'h00;
    tick(2);
    check("t3_req", 32'(IntReq), 32'd1);
    check("t3_id", 32'(IntId), 32'd3);
    rd_chk("t3_pend", 2'd1, 32'h08);
    ack();
    rd_chk("t3_ack_clr", 2'd1, 32'h00);
    rd_chk("t3_svc_status", 2'd3, 32'h230);
    eret();
    do_reset();
    wr(2'd2, 32'h08);
    HWInt = 6'h08;
    tick(1);
    HWInt = 6'h00;
    tick(1);
    rd_chk("t3b_pend", 2'd1, 32'h08);
    HWInt = 6'h08;
    tick(1);
    wr(2'd1, 32'h08);
    HWInt = 6'h00;
    rd_chk("t3b_set_beats_clr", 2'd1, 32'h08);
    tick(2);
    wr(2'd1, 32'h08);
    rd_chk("t3b_w1c", 2'd1, 32'h00);

    // 4: level drop in REQ, then ack in the drop cycle
    do_reset();
    wr(2'd0, 32'h20);
    HWInt = 6'h20;
    tick(3);
    check("t4_req", 32'(IntReq), 32'd1);
    check("t4_id", 32'(IntId), 32'd5);
    HWInt = 6'h00;
    tick(3);
    check("t4_drop_req", 32'(IntReq), 32'd0);
    rd_chk("t4_drop_status", 2'd3, 32'h050);
    do_reset();
    wr(2'd0, 32'h20);
    HWInt = 6'h20;
    tick(3);
    HWInt = 6'h00;
    tick(2);
    ack();
    check("t4b_req", 32'(IntReq), 32'd0);
    rd_chk("t4b_status", 2'd3, 32'h250);

    // 5: no request while in service, eret picks next, reset in REQ
    do_reset();
    wr(2'd2, 32'h02);
    wr(2'd0, 32'h12);
    HWInt = 6'h02;
    tick(3);
    check("t5_id1", 32'(IntId), 32'd1);
    ack();
    HWInt = 6'h12;
    tick(5);
    check("t5_svc_req", 32'(IntReq), 32'd0);
    rd_chk("t5_svc_status", 2'd3, 32'h210);
    rd_chk("t5_pend", 2'd1, 32'h10);
    eret();
    tick(1);
    check("t5_next_req", 32'(IntReq), 32'd1);
    check("t5_next_id", 32'(IntId), 32'd4);
    Reset = 1'b1;
    tick(1);
    check("t5_rst_req", 32'(IntReq), 32'd0);
    check("t5_rst_id", 32'(IntId), 32'd0);
    rd_chk("t5_rst_mask", 2'd0, 32'h0);
    rd_chk("t5_rst_pend", 2'd1, 32'h0);
    rd_chk("t5_rst_edge", 2'd2, 32'h0);
    rd_chk("t5_rst_status", 2'd3, 32'h0);
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
